// File: rtl/exu_lsuagu_split.sv
// exu_lsuagu_split -- load/store address generation and bus sequencing.
//
// Computes the effective address with a private adder. It issues one aligned
// bus beat per access, or two beats when the access crosses a bus-word boundary.
// Load data from the two beats is merged through a leftover buffer. The result
// is sign- or zero-extended and returned on the write-back channel together
// with the error status.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_valid/i_ready     request handshake (ready only while idle)
//   i_rs1, i_imm        base and offset; address = (rs1 + imm) mod 2^ADDR_W
//   i_rs2               store data
//   i_load, i_store     operation kind (neither = no-op write-back)
//   i_size, i_usign     access size (b/h/w/d) and zero-extend select
//   i_itag              tag returned with the result
//   cmd_*               bus command channel (aligned beat address, lanes, mask)
//   rsp_*               bus response channel (read data, error)
//   o_valid/o_ready     write-back handshake
//   o_wdat, o_itag      load result (0 for stores) and tag
//   o_err, o_misalgn    bus error / misaligned trap (MISALGN_SPLIT = 0 only)
module exu_lsuagu_split #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 16,
  parameter int ITAG_W        = 2,
  parameter int MISALGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XLEN-1:0]   i_imm,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [1:0]        i_size,
  input  logic              i_usign,
  input  logic [ITAG_W-1:0] i_itag,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_read,
  output logic [XLEN-1:0]   cmd_wdata,
  output logic [XLEN/8-1:0] cmd_wmask,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [XLEN-1:0]   rsp_rdata,
  input  logic              rsp_err,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [XLEN-1:0]   o_wdat,
  output logic [ITAG_W-1:0] o_itag,
  output logic              o_err,
  output logic              o_misalgn
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, CMD1, RSP1, CMD2, RSP2, WBCK} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic                load_q, load_d;
  logic                usign_q, usign_d;
  logic                cross_q, cross_d;
  logic [1:0]          size_q, size_d;
  logic [ITAG_W-1:0]   itag_q, itag_d;
  logic [XLEN-1:0]     left_q, left_d;
  logic [XLEN-1:0]     wdat_q, wdat_d;
  logic                err_q, err_d;
  logic                misalgn_q, misalgn_d;

  // Keep the low 8<<sz bits of d and sign- or zero-extend them to XLEN.
  function automatic logic [XLEN-1:0] ext_fn(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz,
                                             input logic us);
    int              nbits;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] sbit;
    logic            s;
    nbits = 8 << sz;
    if (nbits >= XLEN) begin
      nbits = XLEN;
      keep  = '1;
    end else begin
      keep = (XLEN'(1) << nbits) - XLEN'(1);
    end
    sbit = XLEN'(1) << (nbits - 1);
    s    = ~us & (|(d & sbit));
    return s ? (d | ~keep) : (d & keep);
  endfunction

  // Byte enables over a two-word window: low half is beat 1, high half beat 2.
  function automatic logic [2*NB-1:0] mask_fn(input logic [1:0] sz,
                                              input logic [OFFW-1:0] off);
    logic [2*NB-1:0] bm;
    bm = ((2*NB)'(1) << (4'd1 << sz)) - (2*NB)'(1);
    return bm << off;
  endfunction

  // Accept-time address and boundary-crossing check.
  logic [ADDR_W-1:0] acc_addr;
  logic [4:0]        acc_end;
  logic              acc_cross;

  assign acc_addr  = i_rs1[ADDR_W-1:0] + i_imm[ADDR_W-1:0];
  assign acc_end   = 5'(acc_addr[OFFW-1:0]) + (5'd1 << i_size);
  assign acc_cross = acc_end > 5'(NB);

  // Lane shifts derived from the captured address offset.
  logic [OFFW-1:0]   off;
  logic [OFFW+2:0]   sh_lo;
  logic [OFFW+3:0]   sh_hi;
  logic [2*NB-1:0]   full_mask;
  logic [ADDR_W-1:0] base_addr;
  logic [XLEN-1:0]   rd_lo;
  logic [XLEN-1:0]   rd_merged;

  assign off       = addr_q[OFFW-1:0];
  assign sh_lo     = {off, 3'b000};
  assign sh_hi     = {(OFFW+1)'(NB) - {1'b0, off}, 3'b000};
  assign full_mask = mask_fn(size_q, off);
  assign base_addr = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign rd_lo     = rsp_rdata >> sh_lo;
  assign rd_merged = left_q | (rsp_rdata << sh_hi);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_valid) begin
        if (!(i_load || i_store))                    state_d = WBCK;
        else if (acc_cross && (MISALGN_SPLIT == 0))  state_d = WBCK;
        else                                         state_d = CMD1;
      end
      CMD1: if (cmd_ready) state_d = RSP1;
      // An error on beat 1 suppresses beat 2.
      RSP1: if (rsp_valid) state_d = (cross_q && !rsp_err) ? CMD2 : WBCK;
      CMD2: if (cmd_ready) state_d = RSP2;
      RSP2: if (rsp_valid) state_d = WBCK;
      WBCK: if (o_ready)   state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // Outputs: purely from state and registers, so they hold under backpressure.
  always_comb begin
    i_ready   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_read  = 1'b0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 1'b0;
    o_valid   = 1'b0;
    o_wdat    = '0;
    o_itag    = '0;
    o_err     = 1'b0;
    o_misalgn = 1'b0;
    case (state_q)
      IDLE: i_ready = 1'b1;
      CMD1: begin
        cmd_valid = 1'b1;
        cmd_addr  = base_addr;
        cmd_read  = load_q;
        cmd_wdata = rs2_q << sh_lo;
        cmd_wmask = full_mask[NB-1:0];
      end
      CMD2: begin
        cmd_valid = 1'b1;
        cmd_addr  = base_addr + ADDR_W'(NB);
        cmd_read  = load_q;
        cmd_wdata = rs2_q >> sh_hi;
        cmd_wmask = full_mask[2*NB-1:NB];
      end
      RSP1, RSP2: rsp_ready = 1'b1;
      WBCK: begin
        o_valid   = 1'b1;
        o_wdat    = wdat_q;
        o_itag    = itag_q;
        o_err     = err_q;
        o_misalgn = misalgn_q;
      end
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    addr_d    = addr_q;
    rs2_d     = rs2_q;
    load_d    = load_q;
    usign_d   = usign_q;
    cross_d   = cross_q;
    size_d    = size_q;
    itag_d    = itag_q;
    left_d    = left_q;
    wdat_d    = wdat_q;
    err_d     = err_q;
    misalgn_d = misalgn_q;
    case (state_q)
      IDLE: if (i_valid) begin
        addr_d    = acc_addr;
        rs2_d     = i_rs2;
        load_d    = i_load;
        usign_d   = i_usign;
        cross_d   = acc_cross;
        size_d    = i_size;
        itag_d    = i_itag;
        left_d    = '0;
        wdat_d    = '0;
        err_d     = 1'b0;
        misalgn_d = (i_load || i_store) && acc_cross && (MISALGN_SPLIT == 0);
      end
      RSP1: if (rsp_valid) begin
        left_d = rd_lo;
        err_d  = rsp_err;
        // Single-beat (or aborted) access: result is final after beat 1.
        if (!(cross_q && !rsp_err))
          wdat_d = load_q ? ext_fn(rd_lo, size_q, usign_q) : '0;
      end
      RSP2: if (rsp_valid) begin
        err_d  = err_q | rsp_err;
        wdat_d = load_q ? ext_fn(rd_merged, size_q, usign_q) : '0;
      end
      WBCK: if (o_ready) begin
        err_d     = 1'b0;
        misalgn_d = 1'b0;
        wdat_d    = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rs2_q     <= '0;
      load_q    <= 1'b0;
      usign_q   <= 1'b0;
      cross_q   <= 1'b0;
      size_q    <= '0;
      itag_q    <= '0;
      left_q    <= '0;
      wdat_q    <= '0;
      err_q     <= 1'b0;
      misalgn_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      rs2_q     <= rs2_d;
      load_q    <= load_d;
      usign_q   <= usign_d;
      cross_q   <= cross_d;
      size_q    <= size_d;
      itag_q    <= itag_d;
      left_q    <= left_d;
      wdat_q    <= wdat_d;
      err_q     <= err_d;
      misalgn_q <= misalgn_d;
    end
  end

endmodule

// File: tb/tb_exu_lsuagu_split.sv
module tb_exu_lsuagu_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_rs1 = '0, i_rs2 = '0, i_imm = '0;
  logic        i_load = 1'b0, i_store = 1'b0, i_usign = 1'b0;
  logic [1:0]  i_size = '0;
  logic [1:0]  i_itag = '0;
  logic        cmd_valid, cmd_read;
  logic        cmd_ready = 1'b0;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid = 1'b0, rsp_err = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_rdata = '0;
  logic        o_valid, o_err, o_misalgn;
  logic        o_ready = 1'b0;
  logic [31:0] o_wdat;
  logic [1:0]  o_itag;

  // Second instance with splitting disabled.
  logic        i_valid2 = 1'b0, i_ready2;
  logic        cmd_valid2, cmd_read2, rsp_ready2;
  logic [15:0] cmd_addr2;
  logic [31:0] cmd_wdata2, o_wdat2;
  logic [3:0]  cmd_wmask2;
  logic        o_valid2, o_err2, o_misalgn2;
  logic        o_ready2 = 1'b0;
  logic [1:0]  o_itag2;

  exu_lsuagu_split #(.XLEN(32), .ADDR_W(16), .ITAG_W(2), .MISALGN_SPLIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .i_load(i_load), .i_store(i_store), .i_size(i_size), .i_usign(i_usign), .i_itag(i_itag),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_read(cmd_read),
    .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_itag(o_itag),
    .o_err(o_err), .o_misalgn(o_misalgn)
  );

  exu_lsuagu_split #(.XLEN(32), .ADDR_W(16), .ITAG_W(2), .MISALGN_SPLIT(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid2), .i_ready(i_ready2), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .i_load(i_load), .i_store(i_store), .i_size(i_size), .i_usign(i_usign), .i_itag(i_itag),
    .cmd_valid(cmd_valid2), .cmd_ready(1'b1), .cmd_addr(cmd_addr2), .cmd_read(cmd_read2),
    .cmd_wdata(cmd_wdata2), .cmd_wmask(cmd_wmask2),
    .rsp_valid(1'b0), .rsp_ready(rsp_ready2), .rsp_rdata(32'h0), .rsp_err(1'b0),
    .o_valid(o_valid2), .o_ready(o_ready2), .o_wdat(o_wdat2), .o_itag(o_itag2),
    .o_err(o_err2), .o_misalgn(o_misalgn2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1, imm, rs2;
    logic        ld, st, us;
    logic [1:0]  sz;
    int          ncmd;
    logic [15:0] a1, a2;
    logic [3:0]  m1, m2;
    logic [31:0] wd1, wd2;
    logic [31:0] rd1, rd2;
    logic        er1, er2;
    logic [31:0] exp_wdat;
    logic        exp_err;
    logic        chkw;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        chkw;
  } cmd_t;

  typedef struct {
    logic [31:0] wdat;
    logic [1:0]  tag;
    logic        err;
    logic        mis;
    logic        chkw;
  } wb_t;

  cmd_t exp_cmd_q[$];
  wb_t  exp_wb_q[$];

  int checks = 0;
  int errors = 0;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One access against the zero-wait (or stalled) bus model.
  task automatic run(input vec_t v, input logic [1:0] tag, input int cstall_in,
                     input int wstall_in, input logic spur);
    cmd_t c;
    wb_t  w;
    int   lat, beat, cstall, wstall;
    bit   done, pend, cmd_hs, rsp_hs, wb_hs;
    cstall = cstall_in;
    wstall = wstall_in;
    if (v.ncmd >= 1) begin
      c = '{v.a1, v.ld, v.wd1, v.m1, v.st};
      exp_cmd_q.push_back(c);
    end
    if (v.ncmd >= 2) begin
      c = '{v.a2, v.ld, v.wd2, v.m2, v.st};
      exp_cmd_q.push_back(c);
    end
    w = '{v.exp_wdat, tag, v.exp_err, 1'b0, v.chkw};
    exp_wb_q.push_back(w);
    @(negedge clk);
    chk("i_ready_idle", 64'(i_ready), 64'(1));
    i_valid = 1'b1; i_rs1 = v.rs1; i_imm = v.imm; i_rs2 = v.rs2;
    i_load = v.ld; i_store = v.st; i_size = v.sz; i_usign = v.us; i_itag = tag;
    @(posedge clk);
    done = 1'b0; pend = 1'b0; beat = 0; lat = -1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      i_valid = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
      rsp_rdata = '0; o_ready = 1'b0;
      chk("i_ready_busy", 64'(i_ready), 64'(0));
      if (pend) begin
        rsp_valid = 1'b1;
        rsp_rdata = (beat == 1) ? v.rd1 : v.rd2;
        rsp_err   = (beat == 1) ? v.er1 : v.er2;
        chk("rsp_ready", 64'(rsp_ready), 64'(1));
      end else begin
        chk("rsp_ready_idle", 64'(rsp_ready), 64'(0));
        if (spur && cmd_valid) begin
          rsp_valid = 1'b1; rsp_rdata = 32'hFFFF_FFFF; rsp_err = 1'b1;
        end
      end
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 64'(cmd_valid), 64'(0));
        else begin
          c = exp_cmd_q[0];
          chk("cmd_addr", 64'(cmd_addr), 64'(c.addr));
          chk("cmd_read", 64'(cmd_read), 64'(c.rd));
          chk("cmd_wmask", 64'(cmd_wmask), 64'(c.wm));
          if (c.chkw) chk("cmd_wdata", 64'(cmd_wdata), 64'(c.wd));
        end
        if (cstall > 0) cstall--;
        else cmd_ready = 1'b1;
      end
      if (o_valid) begin
        if (lat < 0) lat = k;
        if (exp_wb_q.size() == 0) chk("wb_unexpected", 64'(o_valid), 64'(0));
        else begin
          w = exp_wb_q[0];
          if (w.chkw) chk("o_wdat", 64'(o_wdat), 64'(w.wdat));
          chk("o_itag", 64'(o_itag), 64'(w.tag));
          chk("o_err", 64'(o_err), 64'(w.err));
          chk("o_misalgn", 64'(o_misalgn), 64'(w.mis));
        end
        if (wstall > 0) wstall--;
        else o_ready = 1'b1;
      end
      cmd_hs = cmd_valid && cmd_ready;
      rsp_hs = rsp_valid && rsp_ready;
      wb_hs  = o_valid && o_ready;
      @(posedge clk);
      if (cmd_hs) begin
        if (exp_cmd_q.size() > 0) void'(exp_cmd_q.pop_front());
        beat++;
        pend = 1'b1;
      end
      if (rsp_hs && pend) pend = 1'b0;
      if (wb_hs) begin
        if (exp_wb_q.size() > 0) void'(exp_wb_q.pop_front());
        done = 1'b1;
      end
    end
    if (!done) chk("timeout", 64'(done), 64'(1));
    chk("cmd_missing", 64'(exp_cmd_q.size()), 64'(0));
    if (cstall_in == 0 && wstall_in == 0)
      chk("latency", 64'(lat), 64'((v.ncmd == 0) ? 0 : (v.ncmd == 1) ? 2 : 4));
    exp_cmd_q.delete();
    exp_wb_q.delete();
    @(negedge clk);
    o_ready = 1'b0; rsp_valid = 1'b0; cmd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit got;
    //         rs1         imm           rs2           ld    st    us    sz   n  a1      a2      m1       m2       wd1           wd2           rd1           rd2           er1   er2   wdat          err   chkw
    tbl[0]  = '{32'h100,   32'h4,        32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 1, 16'h104, 16'h0,  4'b1111, 4'b0000, 32'h0,        32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[1]  = '{32'h200,   32'h3,        32'h0,        1'b1, 1'b0, 1'b0, 2'd0, 1, 16'h200, 16'h0,  4'b1000, 4'b0000, 32'h0,        32'h0,        32'h80000000, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 1'b0, 1'b1};
    tbl[2]  = '{32'h200,   32'h3,        32'h0,        1'b1, 1'b0, 1'b1, 2'd0, 1, 16'h200, 16'h0,  4'b1000, 4'b0000, 32'h0,        32'h0,        32'h80000000, 32'h0,        1'b0, 1'b0, 32'h00000080, 1'b0, 1'b1};
    tbl[3]  = '{32'h100,   32'h1,        32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 2, 16'h100, 16'h104,4'b1110, 4'b0001, 32'h0,        32'h0,        32'h44332211, 32'h88776655, 1'b0, 1'b0, 32'h55443322, 1'b0, 1'b1};
    tbl[4]  = '{32'h1F0,   32'hE,        32'hAABBCCDD, 1'b0, 1'b1, 1'b0, 2'd2, 2, 16'h1FC, 16'h200,4'b1100, 4'b0011, 32'hCCDD0000, 32'h0000AABB, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[5]  = '{32'h103,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2'd1, 2, 16'h100, 16'h104,4'b1000, 4'b0001, 32'h0,        32'h0,        32'hF1000000, 32'h000000A2, 1'b0, 1'b0, 32'hFFFFA2F1, 1'b0, 1'b1};
    tbl[6]  = '{32'h200,   32'h5,        32'h123456AB, 1'b0, 1'b1, 1'b0, 2'd0, 1, 16'h204, 16'h0,  4'b0010, 4'b0000, 32'h3456AB00, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[7]  = '{32'h300,   32'h2,        32'hFFFF1234, 1'b0, 1'b1, 1'b0, 2'd1, 1, 16'h300, 16'h0,  4'b1100, 4'b0000, 32'h12340000, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[8]  = '{32'h0,     32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 0, 16'h0,   16'h0,  4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    tbl[9]  = '{32'h1FFF0, 32'hE,        32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 2, 16'hFFFC,16'h0000,4'b1100,4'b0011, 32'h0,        32'h0,        32'hBBAA0000, 32'h0000DDCC, 1'b0, 1'b0, 32'hDDCCBBAA, 1'b0, 1'b1};
    tbl[10] = '{32'h210,   32'hFFFFFFF0, 32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 1, 16'h200, 16'h0,  4'b1111, 4'b0000, 32'h0,        32'h0,        32'h01234567, 32'h0,        1'b0, 1'b0, 32'h01234567, 1'b0, 1'b1};
    tbl[11] = '{32'h100,   32'h2,        32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 1, 16'h100, 16'h0,  4'b1100, 4'b0000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0};
    tbl[12] = '{32'h103,   32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 2'd1, 2, 16'h100, 16'h104,4'b1000, 4'b0001, 32'h0,        32'h0,        32'hF1000000, 32'h000000A2, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0};
    tbl[13] = '{32'h103,   32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 2'd1, 2, 16'h100, 16'h104,4'b1000, 4'b0001, 32'h0,        32'h0,        32'hF1000000, 32'h000000A2, 1'b0, 1'b0, 32'h0000A2F1, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_i_ready", 64'(i_ready), 64'(1));
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
    chk("rst_rsp_ready", 64'(rsp_ready), 64'(0));
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_wdat", 64'(o_wdat), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run(tbl[i], 2'(i), 0, 0, 1'b0);

    // Backpressure: cmd_ready low 3 cycles, o_ready low 2, spurious responses.
    run(tbl[3], 2'd1, 3, 2, 1'b1);
    run(tbl[4], 2'd2, 3, 2, 1'b1);

    // Misaligned trap with splitting disabled: lh at 0x3.
    @(negedge clk);
    chk("m_i_ready", 64'(i_ready2), 64'(1));
    i_rs1 = 32'h3; i_imm = 32'h0; i_load = 1'b1; i_store = 1'b0; i_size = 2'd1;
    i_usign = 1'b0; i_itag = 2'd3; i_valid2 = 1'b1;
    @(posedge clk);
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk);
      i_valid2 = 1'b0; o_ready2 = 1'b0;
      chk("m_cmd_valid", 64'(cmd_valid2), 64'(0));
      if (o_valid2) begin
        chk("m_misalgn", 64'(o_misalgn2), 64'(1));
        chk("m_wdat", 64'(o_wdat2), 64'(0));
        chk("m_err", 64'(o_err2), 64'(0));
        chk("m_itag", 64'(o_itag2), 64'(3));
        chk("m_latency", 64'(k), 64'(0));
        o_ready2 = 1'b1;
        got = 1'b1;
      end
      @(posedge clk);
    end
    if (!got) chk("m_timeout", 64'(got), 64'(1));
    @(negedge clk);
    o_ready2 = 1'b0;
    chk("m_o_valid_clr", 64'(o_valid2), 64'(0));
    chk("m_misalgn_clr", 64'(o_misalgn2), 64'(0));
    chk("m_i_ready_back", 64'(i_ready2), 64'(1));

    // Reset during RSP1, then a late response must produce nothing.
    i_rs1 = 32'h100; i_imm = 32'h0; i_load = 1'b1; i_size = 2'd2; i_itag = 2'd0;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("r_cmd_valid", 64'(cmd_valid), 64'(1));
    cmd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("r_rsp_ready", 64'(rsp_ready), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("r_i_ready", 64'(i_ready), 64'(1));
    chk("r_rsp_ready_rst", 64'(rsp_ready), 64'(0));
    chk("r_cmd_valid_rst", 64'(cmd_valid), 64'(0));
    chk("r_o_valid_rst", 64'(o_valid), 64'(0));
    chk("r_o_wdat_rst", 64'(o_wdat), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("r_late_o_valid", 64'(o_valid), 64'(0));
      chk("r_late_cmd_valid", 64'(cmd_valid), 64'(0));
    end
    rsp_valid = 1'b0;

    // Normal operation resumes after the abandoned access.
    run(tbl[0], 2'd2, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
